// File: rtl/arcade_input_mapper.sv
// Arcade control front end: PS/2 key decode, joystick merge, rotation, autofire,
// fixed-width coin pulses and an optional coin-on-start sequencer per player.
module arcade_input_mapper #(
    parameter int PLAYERS     = 2,
    parameter int COIN_CYCLES = 120000,
    parameter int GAP_CYCLES  = 60000,
    parameter int AF_HALF     = 400000
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic [10:0] ps2_key,
    input  logic [15:0] joystick_0,
    input  logic [15:0] joystick_1,
    input  logic [1:0]  rotate,
    input  logic        autofire_en,
    input  logic        coin_on_start,
    output logic [6:0]  joy_pcfrldu_1,
    output logic [6:0]  joy_pcfrldu_2,
    output logic        btn_test
);
    localparam int MAX_AB = (COIN_CYCLES > GAP_CYCLES) ? COIN_CYCLES : GAP_CYCLES;
    localparam int MAXP   = (MAX_AB > AF_HALF) ? MAX_AB : AF_HALF;
    localparam int CW     = $clog2(MAXP) + 1;

    localparam logic [CW-1:0] COIN_LAST = CW'(COIN_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);
    localparam logic [CW-1:0] AF_LAST   = CW'(AF_HALF - 1);

    localparam int K_UP1    = 0;
    localparam int K_DOWN1  = 1;
    localparam int K_LEFT1  = 2;
    localparam int K_RIGHT1 = 3;
    localparam int K_FIRE1  = 4;
    localparam int K_START1 = 5;
    localparam int K_COIN1  = 6;
    localparam int K_UP2    = 7;
    localparam int K_DOWN2  = 8;
    localparam int K_LEFT2  = 9;
    localparam int K_RIGHT2 = 10;
    localparam int K_FIRE2  = 11;
    localparam int K_START2 = 12;
    localparam int K_COIN2  = 13;
    localparam int K_TEST   = 14;
    localparam int NK       = 15;

    typedef enum logic [1:0] {S_IDLE, S_COIN, S_GAP, S_START} state_t;

    logic          toggle_reg;
    logic [NK-1:0] keys_reg;
    logic [NK-1:0] key_hit;
    logic          key_event;
    logic          btn_test_reg;
    logic          ext;

    assign key_event = ps2_key[10] != toggle_reg;
    assign ext       = ps2_key[8];

    always_comb begin
        key_hit = '0;
        case (ps2_key[7:0])
            8'h75: key_hit[K_UP1]    = 1'b1;
            8'h72: key_hit[K_DOWN1]  = 1'b1;
            8'h6B: key_hit[K_LEFT1]  = 1'b1;
            8'h74: key_hit[K_RIGHT1] = 1'b1;
            8'h14: key_hit[K_FIRE1]  = 1'b1;
            8'h29: key_hit[K_FIRE1]  = ~ext;
            8'h05: key_hit[K_START1] = ~ext;
            8'h16: key_hit[K_START1] = ~ext;
            8'h2E: key_hit[K_COIN1]  = ~ext;
            8'h06: key_hit[K_START2] = ~ext;
            8'h1E: key_hit[K_START2] = ~ext;
            8'h36: key_hit[K_COIN2]  = ~ext;
            8'h2D: key_hit[K_UP2]    = ~ext;
            8'h2B: key_hit[K_DOWN2]  = ~ext;
            8'h23: key_hit[K_LEFT2]  = ~ext;
            8'h34: key_hit[K_RIGHT2] = ~ext;
            8'h1C: key_hit[K_FIRE2]  = ~ext;
            8'h2C: key_hit[K_TEST]   = ~ext;
            default: ;
        endcase
    end

    // The toggle copy loads the live bit in reset so leaving reset never fakes an event.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            toggle_reg   <= ps2_key[10];
            keys_reg     <= '0;
            btn_test_reg <= 1'b0;
        end else begin
            toggle_reg   <= ps2_key[10];
            btn_test_reg <= keys_reg[K_TEST];
            if (key_event) begin
                keys_reg <= (keys_reg & ~key_hit) | (key_hit & {NK{ps2_key[9]}});
            end
        end
    end

    // Raw vectors use the output bit order {coin, start, fire, right, left, down, up}.
    logic [6:0]      keys1_vec, keys2_vec, joy0_vec, joy1_vec;
    logic [1:0][6:0] raw_vec;
    logic [1:0][6:0] out_vec;

    assign keys1_vec = {keys_reg[K_COIN1], keys_reg[K_START1], keys_reg[K_FIRE1],
                        keys_reg[K_RIGHT1], keys_reg[K_LEFT1], keys_reg[K_DOWN1], keys_reg[K_UP1]};
    assign keys2_vec = {keys_reg[K_COIN2], keys_reg[K_START2], keys_reg[K_FIRE2],
                        keys_reg[K_RIGHT2], keys_reg[K_LEFT2], keys_reg[K_DOWN2], keys_reg[K_UP2]};
    assign joy0_vec  = {joystick_0[7], joystick_0[5], joystick_0[4],
                        joystick_0[0], joystick_0[1], joystick_0[2], joystick_0[3]};
    assign joy1_vec  = {joystick_1[7], joystick_1[6], joystick_1[4],
                        joystick_1[0], joystick_1[1], joystick_1[2], joystick_1[3]};

    always_comb begin
        raw_vec = '0;
        if (PLAYERS == 1) begin
            raw_vec[0]    = keys1_vec | keys2_vec | joy0_vec | joy1_vec;
            raw_vec[0][5] = raw_vec[0][5] | joystick_0[6] | joystick_1[5];
        end else begin
            raw_vec[0] = keys1_vec | joy0_vec;
            raw_vec[1] = keys2_vec | joy1_vec;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_player
            if (gi < PLAYERS) begin : g_on
                logic [6:0]    raw;
                logic [3:0]    dir_rot;
                logic [CW-1:0] af_cnt_reg;
                logic          af_phase_reg;
                state_t        state_reg, state_next;
                logic [CW-1:0] cnt_reg, cnt_next;
                logic          seq_reg, seq_next;
                logic          coin_prev_reg, start_prev_reg;
                logic          coin_rise, start_rise, seq_busy;
                logic [6:0]    out_reg, out_next;

                assign raw        = raw_vec[gi];
                assign coin_rise  = raw[6] & ~coin_prev_reg;
                assign start_rise = raw[5] & ~start_prev_reg;
                assign seq_busy   = seq_reg & (state_reg != S_IDLE);

                always_comb begin
                    case (rotate)
                        2'd1:    dir_rot = {raw[0], raw[1], raw[3], raw[2]};
                        2'd2:    dir_rot = {raw[1], raw[0], raw[2], raw[3]};
                        default: dir_rot = raw[3:0];
                    endcase
                end

                // A released fire parks the phase high so the next press starts with a shot.
                always_ff @(posedge clk_sys) begin
                    if (reset || !raw[4]) begin
                        af_cnt_reg   <= '0;
                        af_phase_reg <= 1'b1;
                    end else if (af_cnt_reg == AF_LAST) begin
                        af_cnt_reg   <= '0;
                        af_phase_reg <= ~af_phase_reg;
                    end else begin
                        af_cnt_reg   <= af_cnt_reg + 1'b1;
                    end
                end

                always_ff @(posedge clk_sys) begin
                    if (reset) begin
                        state_reg      <= S_IDLE;
                        cnt_reg        <= '0;
                        seq_reg        <= 1'b0;
                        coin_prev_reg  <= 1'b0;
                        start_prev_reg <= 1'b0;
                        out_reg        <= '0;
                    end else begin
                        state_reg      <= state_next;
                        cnt_reg        <= cnt_next;
                        seq_reg        <= seq_next;
                        coin_prev_reg  <= raw[6];
                        start_prev_reg <= raw[5];
                        out_reg        <= out_next;
                    end
                end

                // COIN is shared: seq_reg chooses between a plain pulse and the full sequence.
                always_comb begin
                    state_next = state_reg;
                    cnt_next   = cnt_reg;
                    seq_next   = seq_reg;
                    case (state_reg)
                        S_IDLE: begin
                            cnt_next = '0;
                            if (coin_rise) begin
                                state_next = S_COIN;
                                seq_next   = 1'b0;
                            end else if (start_rise && coin_on_start) begin
                                state_next = S_COIN;
                                seq_next   = 1'b1;
                            end
                        end
                        S_COIN: begin
                            if (cnt_reg == COIN_LAST) begin
                                cnt_next   = '0;
                                state_next = seq_reg ? S_GAP : S_IDLE;
                            end else begin
                                cnt_next = cnt_reg + 1'b1;
                            end
                        end
                        S_GAP: begin
                            if (cnt_reg == GAP_LAST) begin
                                cnt_next   = '0;
                                state_next = S_START;
                            end else begin
                                cnt_next = cnt_reg + 1'b1;
                            end
                        end
                        S_START: begin
                            if (cnt_reg == COIN_LAST) begin
                                cnt_next   = '0;
                                state_next = S_IDLE;
                            end else begin
                                cnt_next = cnt_reg + 1'b1;
                            end
                        end
                        default: state_next = S_IDLE;
                    endcase
                end

                always_comb begin
                    out_next      = '0;
                    out_next[6]   = (state_reg == S_COIN);
                    out_next[5]   = (state_reg == S_START) | (~coin_on_start & ~seq_busy & raw[5]);
                    out_next[4]   = raw[4] & (af_phase_reg | ~autofire_en);
                    out_next[3:0] = dir_rot;
                end

                assign out_vec[gi] = out_reg;
            end else begin : g_off
                assign out_vec[gi] = '0;
            end
        end
    endgenerate

    logic unused_bits;
    assign unused_bits = &{1'b0, joystick_0[15:8], joystick_1[15:8], raw_vec};

    assign joy_pcfrldu_1 = out_vec[0];
    assign joy_pcfrldu_2 = out_vec[1];
    assign btn_test      = btn_test_reg;
endmodule
